// File: rtl/spr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spr_pkg
// Purpose  : Shared defaults and reserved-entry constants for the SPR file
//            and its time-base/decrementer engine.
// Revision : 1.0 - initial release
// ============================================================================
package spr_pkg;

  // Default geometry of the register file
  localparam int c_width  = 32;
  localparam int c_addr_w = 5;
  localparam int c_nreg   = 32;

  // Reserved entries with autonomous behaviour
  localparam int c_tbl_idx = 28;
  localparam int c_tbu_idx = 29;
  localparam int c_dec_idx = 22;

  // Decrementer reset value and the all-ones word (TBL carry-out detect)
  localparam logic [c_width-1:0] c_dec_rst  = '0;
  localparam logic [c_width-1:0] c_all_ones = '1;

endpackage
`default_nettype wire

// File: rtl/spr_timer.sv
`default_nettype none
// ============================================================================
// Module   : spr_timer
// Purpose  : Next-state logic for TBL/TBU/DEC and the sticky decrementer
//            interrupt. Software writes take priority over ticks per entry;
//            the TBL carry is always taken from the pre-edge TBL value.
// Revision : 1.0 - initial release
// ============================================================================
module spr_timer
  import spr_pkg::*;
#(
  parameter int WIDTH = c_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_tbl,
  input  logic [WIDTH-1:0] i_tbu,
  input  logic [WIDTH-1:0] i_dec,
  input  logic             i_hit_tbl,
  input  logic             i_hit_tbu,
  input  logic             i_hit_dec,
  input  logic [WIDTH-1:0] i_wd_tbl,
  input  logic [WIDTH-1:0] i_wd_tbu,
  input  logic [WIDTH-1:0] i_wd_dec,
  input  logic             i_tb_en,
  input  logic             i_dec_ack,
  output logic [WIDTH-1:0] o_tbl_nxt,
  output logic [WIDTH-1:0] o_tbu_nxt,
  output logic [WIDTH-1:0] o_dec_nxt,
  output logic             o_dec_irq
);

  logic w_carry;
  logic w_irq_set;
  logic r_dec_irq;

  // Tick/write selection per entry; carry uses pre-edge TBL even when TBL is written
  always_comb begin
    w_carry   = i_tb_en && (i_tbl == WIDTH'(c_all_ones));
    w_irq_set = i_tb_en && !i_hit_dec && (i_dec == '0);
    o_tbl_nxt = i_hit_tbl ? i_wd_tbl : (i_tb_en ? i_tbl + WIDTH'(1) : i_tbl);
    o_tbu_nxt = i_hit_tbu ? i_wd_tbu : (w_carry ? i_tbu + WIDTH'(1) : i_tbu);
    o_dec_nxt = i_hit_dec ? i_wd_dec : (i_tb_en ? i_dec - WIDTH'(1) : i_dec);
  end

  // Sticky interrupt: set beats acknowledge; DEC writes never touch it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_dec_irq <= 1'b1;
    end else if (i_dec_ack) begin
      r_dec_irq <= 1'b0;
    end
  end

  assign o_dec_irq = r_dec_irq;

endmodule
`default_nettype wire

// File: rtl/spr_file_tb.sv
`default_nettype none
// ============================================================================
// Module   : spr_file_tb
// Purpose  : Special-purpose register file: NRD combinational read ports,
//            NWR synchronous write ports (highest port wins), 64-bit time
//            base (TBL/TBU) and decrementer with sticky interrupt.
// Options  : SPR_BYPASS_EN - forward same-cycle write data to read ports.
//            Reserved indices must lie below NREG.
// Revision : 1.0 - initial release
// ============================================================================
module spr_file_tb
  import spr_pkg::*;
#(
  parameter int WIDTH   = c_width,
  parameter int ADDR_W  = c_addr_w,
  parameter int NREG    = c_nreg,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int TBL_IDX = c_tbl_idx,
  parameter int TBU_IDX = c_tbu_idx,
  parameter int DEC_IDX = c_dec_idx
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NWR-1:0]          i_wr,
  input  logic [NWR*ADDR_W-1:0]   i_waddr,
  input  logic [NWR*WIDTH-1:0]    i_wd,
  input  logic [NRD*ADDR_W-1:0]   i_raddr,
  output logic [NRD*WIDTH-1:0]    o_rd,
  input  logic                    i_tb_en,
  input  logic                    i_dec_ack,
  output logic                    o_dec_irq
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] w_next [NREG];
  logic [WIDTH-1:0] w_wdat [NREG];
  logic [NREG-1:0]  w_hit;
  logic [WIDTH-1:0] w_tbl_nxt;
  logic [WIDTH-1:0] w_tbu_nxt;
  logic [WIDTH-1:0] w_dec_nxt;

  // Per-entry write arbitration: later (higher) ports overwrite earlier ones;
  // out-of-range addresses simply match no entry
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_hit[i]  = 1'b0;
      w_wdat[i] = '0;
      for (int p = 0; p < NWR; p++) begin
        if (i_wr[p] && (i_waddr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
          w_hit[i]  = 1'b1;
          w_wdat[i] = i_wd[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  spr_timer #(
    .WIDTH (WIDTH)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_tbl     (r_regs[TBL_IDX]),
    .i_tbu     (r_regs[TBU_IDX]),
    .i_dec     (r_regs[DEC_IDX]),
    .i_hit_tbl (w_hit[TBL_IDX]),
    .i_hit_tbu (w_hit[TBU_IDX]),
    .i_hit_dec (w_hit[DEC_IDX]),
    .i_wd_tbl  (w_wdat[TBL_IDX]),
    .i_wd_tbu  (w_wdat[TBU_IDX]),
    .i_wd_dec  (w_wdat[DEC_IDX]),
    .i_tb_en   (i_tb_en),
    .i_dec_ack (i_dec_ack),
    .o_tbl_nxt (w_tbl_nxt),
    .o_tbu_nxt (w_tbu_nxt),
    .o_dec_nxt (w_dec_nxt),
    .o_dec_irq (o_dec_irq)
  );

  // Next value per entry: timer-owned entries come from spr_timer
  for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
    if (gi == TBL_IDX) begin : g_tbl
      assign w_next[gi] = w_tbl_nxt;
    end else if (gi == TBU_IDX) begin : g_tbu
      assign w_next[gi] = w_tbu_nxt;
    end else if (gi == DEC_IDX) begin : g_dec
      assign w_next[gi] = w_dec_nxt;
    end else begin : g_plain
      assign w_next[gi] = w_hit[gi] ? w_wdat[gi] : r_regs[gi];
    end
  end

  // Storage update; reset discards any same-cycle write or tick
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == DEC_IDX) ? WIDTH'(c_dec_rst) : '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= w_next[i];
      end
    end
  end

  // Read muxes: unmatched (out-of-range) addresses return zero
  always_comb begin
    o_rd = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 0; i < NREG; i++) begin
        if (i_raddr[p*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
`ifdef SPR_BYPASS_EN
          o_rd[p*WIDTH +: WIDTH] = w_hit[i] ? w_wdat[i] : r_regs[i];
`else
          o_rd[p*WIDTH +: WIDTH] = r_regs[i];
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spr_file_tb.sv
`default_nettype none
// ============================================================================
// Module   : tb_spr_file_tb
// Purpose  : Directed bench for spr_file_tb: a 32-entry and a 24-entry
//            instance share stimulus and are compared against a behavioural
//            register-file model every cycle, plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spr_file_tb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  wr = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wd = '0;
  logic [9:0]  raddr = '0;
  logic        tb_en = 1'b0;
  logic        dec_ack = 1'b0;
  logic [63:0] rd32, rd24;
  logic        irq32, irq24;

  int nvec = 0;
  int nmis = 0;

  // model state: instance 0 = 32 entries, instance 1 = 24 entries
  logic [31:0] m [2][32];
  logic        mirq [2];
  int          mnreg [2] = '{32, 24};
  int          mtbl  [2] = '{28, 16};
  int          mtbu  [2] = '{29, 17};
  int          mdec  [2] = '{22, 22};

  always #5 clk = ~clk;

  spr_file_tb u_dut32 (
    .clk (clk), .rst (rst), .i_wr (wr), .i_waddr (waddr), .i_wd (wd),
    .i_raddr (raddr), .o_rd (rd32), .i_tb_en (tb_en), .i_dec_ack (dec_ack),
    .o_dec_irq (irq32)
  );

  spr_file_tb #(
    .NREG (24), .TBL_IDX (16), .TBU_IDX (17), .DEC_IDX (22)
  ) u_dut24 (
    .clk (clk), .rst (rst), .i_wr (wr), .i_waddr (waddr), .i_wd (wd),
    .i_raddr (raddr), .o_rd (rd24), .i_tb_en (tb_en), .i_dec_ack (dec_ack),
    .o_dec_irq (irq24)
  );

  // Register-file semantics applied to pre-edge state
  task automatic model_update();
    logic [31:0] n [32];
    bit          w [32];
    int          a;
    bit          set;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
        mirq[k] = 1'b0;
      end else begin
        for (int i = 0; i < 32; i++) begin n[i] = m[k][i]; w[i] = 1'b0; end
        for (int p = 0; p < 2; p++) begin
          a = int'(waddr[p*5 +: 5]);
          if (wr[p] && a < mnreg[k]) begin n[a] = wd[p*32 +: 32]; w[a] = 1'b1; end
        end
        set = 1'b0;
        if (tb_en) begin
          if (!w[mtbl[k]]) n[mtbl[k]] = m[k][mtbl[k]] + 32'd1;
          if (m[k][mtbl[k]] == 32'hFFFF_FFFF && !w[mtbu[k]]) n[mtbu[k]] = m[k][mtbu[k]] + 32'd1;
          if (!w[mdec[k]]) begin
            n[mdec[k]] = m[k][mdec[k]] - 32'd1;
            set = (m[k][mdec[k]] == 32'h0);
          end
        end
        if (set) mirq[k] = 1'b1;
        else if (dec_ack) mirq[k] = 1'b0;
        for (int i = 0; i < 32; i++) m[k][i] = n[i];
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(int k, int p);
    int a;
    logic [31:0] v;
    a = int'(raddr[p*5 +: 5]);
    v = (a < mnreg[k]) ? m[k][a] : 32'h0;
`ifdef SPR_BYPASS_EN
    for (int q = 0; q < 2; q++)
      if (wr[q] && int'(waddr[q*5 +: 5]) == a && a < mnreg[k]) v = wd[q*32 +: 32];
`endif
    return v;
  endfunction

  // Compare every DUT output against the model
  task automatic check();
    logic [31:0] got;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        got = (k == 0) ? rd32[p*32 +: 32] : rd24[p*32 +: 32];
        nvec++;
        if (got !== exp_rd(k, p)) begin
          nmis++;
          $display("FAIL rd inst%0d port%0d addr %0d: got %h expected %h at %0t",
                   k, p, raddr[p*5 +: 5], got, exp_rd(k, p), $time);
        end
      end
      nvec++;
      if (((k == 0) ? irq32 : irq24) !== mirq[k]) begin
        nmis++;
        $display("FAIL dec_irq inst%0d: got %b expected %b at %0t",
                 k, (k == 0) ? irq32 : irq24, mirq[k], $time);
      end
    end
  endtask

  task automatic tick();
    #1 check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wrp(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                     input logic [4:0] a1, input logic [31:0] d1);
    wr = en; waddr = {a1, a0}; wd = {d1, d0};
  endtask

  task automatic lit(input string nm, input int inst, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] got;
    raddr[4:0] = a;
    #1;
    got = (inst == 0) ? rd32[31:0] : rd24[31:0];
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic lit_irq(input string nm, input logic exp);
    nvec++;
    if (irq32 !== exp) begin
      nmis++;
      $display("FAIL %s: dec_irq got %b expected %b", nm, irq32, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;

    // reset clears storage and discards a same-cycle write/tick
    wrp(2'b01, 5'd3, 32'h1234_5678, 5'd0, 32'h0); tick();
    wr = '0; lit("wr_e3", 0, 5'd3, 32'h1234_5678);
    rst = 1'b1; wrp(2'b01, 5'd3, 32'h0000_DEAD, 5'd0, 32'h0); tb_en = 1'b1; tick();
    rst = 1'b0; wr = '0; tb_en = 1'b0;
    lit("rst_e3", 0, 5'd3, 32'h0); lit("rst_tbl", 0, 5'd28, 32'h0); lit_irq("rst_irq", 1'b0); tick();
    lit("rst_tbu", 0, 5'd29, 32'h0); lit("rst_dec", 0, 5'd22, 32'h0); tick();

    // write priority
    wrp(2'b11, 5'd5, 32'hAAAA_0000, 5'd5, 32'h5555_FFFF);
`ifdef SPR_BYPASS_EN
    lit("prio_same_cycle", 0, 5'd5, 32'h5555_FFFF);
`else
    lit("prio_same_cycle", 0, 5'd5, 32'h0);
`endif
    tick();
    wr = '0; lit("prio", 0, 5'd5, 32'h5555_FFFF); tick();

    // time-base carry
    wrp(2'b11, 5'd28, 32'hFFFF_FFFE, 5'd29, 32'h7); tick();
    wr = '0; tb_en = 1'b1; tick(); tick(); tb_en = 1'b0;
    lit("tb_tbl0", 0, 5'd28, 32'h0); lit("tb_tbu8", 0, 5'd29, 32'h8); tick();
    tb_en = 1'b1; tick(); tb_en = 1'b0;
    lit("tb_tbl1", 0, 5'd28, 32'h1); tick();
    dec_ack = 1'b1; tick(); dec_ack = 1'b0; lit_irq("ack0", 1'b0);

    // decrementer wrap and interrupt
    wrp(2'b01, 5'd22, 32'h2, 5'd0, 32'h0); tick();
    wr = '0; tb_en = 1'b1; tick();
    lit("dec1", 0, 5'd22, 32'h1); tick();
    lit("dec0", 0, 5'd22, 32'h0); lit_irq("irq_before_wrap", 1'b0); tick();
    lit("dec_wrap", 0, 5'd22, 32'hFFFF_FFFF); lit_irq("irq_set", 1'b1);
    tb_en = 1'b0; tick(); tick(); lit_irq("irq_sticky", 1'b1);
    dec_ack = 1'b1; tick(); dec_ack = 1'b0; lit_irq("irq_ack", 1'b0);

    // set beats ack; DEC write does not clear
    wrp(2'b01, 5'd22, 32'h0, 5'd0, 32'h0); tick();
    wr = '0; tb_en = 1'b1; dec_ack = 1'b1; tick();
    tb_en = 1'b0; dec_ack = 1'b0; lit_irq("set_beats_ack", 1'b1);
    wrp(2'b01, 5'd22, 32'h5, 5'd0, 32'h0); tick();
    wr = '0; lit_irq("write_keeps_irq", 1'b1);
    dec_ack = 1'b1; tick(); dec_ack = 1'b0;

    // write vs tick on DEC
    wrp(2'b01, 5'd22, 32'h10, 5'd0, 32'h0); tick();
    tb_en = 1'b1; wrp(2'b01, 5'd22, 32'h100, 5'd0, 32'h0); tick();
    wr = '0; lit("dec_write_wins", 0, 5'd22, 32'h100); tick();
    tb_en = 1'b0; lit("dec_after", 0, 5'd22, 32'hFF); tick();
    wrp(2'b01, 5'd22, 32'hFFFF_FFFF, 5'd0, 32'h0); tick();
    wr = '0; tick(); lit_irq("sw_msb_no_irq", 1'b0);

    // write to TBU only during carry
    wrp(2'b11, 5'd28, 32'hFFFF_FFFF, 5'd29, 32'h3); tick();
    tb_en = 1'b1; wrp(2'b10, 5'd0, 32'h0, 5'd29, 32'h50); tick();
    tb_en = 1'b0; wr = '0;
    lit("tbu_write_wins", 0, 5'd29, 32'h50); lit("tbl_ticked", 0, 5'd28, 32'h0); tick();
    // write to TBL only during carry
    wrp(2'b11, 5'd28, 32'hFFFF_FFFF, 5'd29, 32'h3); tick();
    tb_en = 1'b1; wrp(2'b01, 5'd28, 32'h1234, 5'd0, 32'h0); tick();
    tb_en = 1'b0; wr = '0;
    lit("tbl_write_wins", 0, 5'd28, 32'h1234); lit("tbu_carried", 0, 5'd29, 32'h4); tick();
    // TBU wrap
    wrp(2'b11, 5'd28, 32'hFFFF_FFFF, 5'd29, 32'hFFFF_FFFF); tick();
    wr = '0; tb_en = 1'b1; tick(); tb_en = 1'b0;
    lit("wrap_tbl", 0, 5'd28, 32'h0); lit("wrap_tbu", 0, 5'd29, 32'h0); tick();

    // out-of-range on the 24-entry instance
    wrp(2'b01, 5'd30, 32'hCAFE_BABE, 5'd0, 32'h0);
    lit("oor_same_cycle", 1, 5'd30, 32'h0); tick();
    wr = '0; lit("oor_read", 1, 5'd30, 32'h0); lit("inrange_32", 0, 5'd30, 32'hCAFE_BABE); tick();

    // full read sweep of both instances
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
